// File: rtl/hms_clock_ctrl.sv
// hms_clock_ctrl: mode/setup controller for the HMS clock, turning debounced buttons
// and the 1 Hz time base into single-cycle counter increment enables plus a blink mask.
module hms_clock_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DEB_DIV   = 500_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_wrap,
    input  logic       i_min_wrap,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_hour_inc,
    output logic [5:0] o_blink_mask,
    output logic       o_tick_1hz
);
    localparam int CW = $clog2(CLK_HZ);
    localparam int DW = $clog2(DEB_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {CLOCK, SETUP} mode_t;

    mode_t         state, state_n;
    logic [2:0]    sw, s1, s2, smp, lvl, armed, press, agree;
    logic [DW-1:0] deb_cnt;
    logic          deb_tick;
    logic [CW-1:0] sec_cnt;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          phase, phase_n, tick, blink_wrap;
    logic [1:0]    pos, pos_n;
    logic [2:0]    inc, inc_n;
    logic          e0, e1, e2;

    assign sw       = {i_sw2, i_sw1, i_sw0};
    assign deb_tick = deb_cnt == DW'(DEB_DIV - 1);
    assign agree    = ~(s2 ^ smp);

    // Buttons idle high; armed stays clear until a genuine release is seen, so a
    // button held through reset cannot produce a press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '1;
            s2      <= '1;
            smp     <= '1;
            lvl     <= '1;
            armed   <= '0;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            s1      <= sw;
            s2      <= s1;
            deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
            press   <= {3{deb_tick}} & agree & ~s2 & lvl & armed;
            if (deb_tick) begin
                smp   <= s2;
                lvl   <= (agree & s2) | (~agree & lvl);
                armed <= armed | (agree & s2);
            end
        end
    end

    assign e0         = press[0];
    assign e1         = press[1] & ~press[0];
    assign e2         = press[2] & ~|press[1:0];
    assign tick       = state == CLOCK && sec_cnt == CW'(CLK_HZ - 1);
    assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);

    always_comb begin
        state_n     = e0 ? (state == CLOCK ? SETUP : CLOCK) : state;
        pos_n       = (e0 && state == CLOCK) ? 2'd0 :
                      (e1 && state == SETUP) ? (pos == 2'd2 ? 2'd0 : pos + 2'd1) : pos;
        inc_n       = (e2 && state == SETUP) ? 3'b001 << pos : 3'b000;
        blink_cnt_n = (state == SETUP && !e0 && !blink_wrap) ? blink_cnt + 1'b1 : '0;
        phase_n     = state == SETUP && !e0 && (phase ^ blink_wrap);
    end

    // The 1 Hz counter is parked at 0 through SETUP so CLOCK resumes on a full second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLOCK;
            pos       <= 2'd0;
            inc       <= 3'b000;
            blink_cnt <= '0;
            phase     <= 1'b0;
            sec_cnt   <= '0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            inc       <= inc_n;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            sec_cnt   <= (state == SETUP || tick) ? '0 : sec_cnt + 1'b1;
        end
    end

    assign o_mode       = state == SETUP;
    assign o_position   = pos;
    assign o_tick_1hz   = tick;
    assign o_sec_inc    = o_mode ? inc[0] : tick;
    assign o_min_inc    = !rst && (o_mode ? inc[1] : i_sec_wrap);
    assign o_hour_inc   = !rst && (o_mode ? inc[2] : i_min_wrap);
    assign o_blink_mask = {6{phase}} & {{2{pos == 2'd2}}, {2{pos == 2'd1}}, {2{pos == 2'd0}}};
endmodule

// File: tb/tb_hms_clock_ctrl.sv
// tb_hms_clock_ctrl: checks hms_clock_ctrl every cycle against a sample-point/event
// model of the button, mode and time-base rules, plus literal scenario expectations.
module tb_hms_clock_ctrl;
    localparam int CLK_HZ = 10, DEB_DIV = 4, BLINK_DIV = 5;

    logic clk = 0, rst = 1;
    logic i_sw0 = 1, i_sw1 = 1, i_sw2 = 1, i_sec_wrap = 0, i_min_wrap = 0;
    logic o_mode, o_sec_inc, o_min_inc, o_hour_inc, o_tick_1hz;
    logic [1:0] o_position;
    logic [5:0] o_blink_mask;

    hms_clock_ctrl #(.CLK_HZ(CLK_HZ), .DEB_DIV(DEB_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst(rst), .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2),
        .i_sec_wrap(i_sec_wrap), .i_min_wrap(i_min_wrap), .o_mode(o_mode),
        .o_position(o_position), .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc),
        .o_hour_inc(o_hour_inc), .o_blink_mask(o_blink_mask), .o_tick_1hz(o_tick_1hz)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cnt_sec = 0, cnt_min = 0, cnt_hour = 0, cnt_tick = 0;

    // Model: mk = edges since reset release, ms = edge the time base restarted,
    // me = edge SETUP was entered; button inputs recorded per edge.
    int mk, ms, me, mpos;
    logic mmode;
    logic [2:0] msmp, mlvl, marm, mpend, minc;
    logic [2:0] swh [0:16383];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [2:0] sync, ev;
        if (rst) begin
            mk = 0; ms = 0; me = 0; mpos = 0; mmode = 0;
            msmp = '1; mlvl = '1; marm = '0; mpend = '0; minc = '0;
            return;
        end
        mk++;
        minc = '0;
        if (mpend[0]) begin
            if (!mmode) begin mmode = 1; mpos = 0; me = mk; end
            else begin mmode = 0; ms = mk; end
        end else if (mpend[1]) begin
            if (mmode) mpos = (mpos + 1) % 3;
        end else if (mpend[2]) begin
            if (mmode) minc[mpos] = 1'b1;
        end
        if (mk < 16384) swh[mk] = {i_sw2, i_sw1, i_sw0};
        sync = (mk >= 3 && mk < 16386) ? swh[mk-2] : 3'b111;
        ev = '0;
        if (mk % DEB_DIV == 0)
            for (int b = 0; b < 3; b++) begin
                if (sync[b] == msmp[b]) begin
                    if (!sync[b] && mlvl[b] && marm[b]) ev[b] = 1'b1;
                    mlvl[b] = sync[b];
                    if (sync[b]) marm[b] = 1'b1;
                end
                msmp[b] = sync[b];
            end
        mpend = ev;
    endtask

    task automatic compare();
        logic etick;
        logic [5:0] emask;
        etick = !mmode && ((mk - ms) % CLK_HZ == CLK_HZ - 1);
        emask = (mmode && ((mk - me) / BLINK_DIV) % 2 == 1) ? 6'b000011 << (2 * mpos) : 6'b0;
        chk("mode", int'(o_mode), int'(mmode));
        chk("position", int'(o_position), mpos);
        chk("tick_1hz", int'(o_tick_1hz), int'(etick));
        chk("sec_inc", int'(o_sec_inc), int'(mmode ? minc[0] : etick));
        chk("min_inc", int'(o_min_inc), int'(!rst && (mmode ? minc[1] : i_sec_wrap)));
        chk("hour_inc", int'(o_hour_inc), int'(!rst && (mmode ? minc[2] : i_min_wrap)));
        chk("blink_mask", int'(o_blink_mask), int'(emask));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        cnt_sec += int'(o_sec_inc);
        cnt_min += int'(o_min_inc);
        cnt_hour += int'(o_hour_inc);
        cnt_tick += int'(o_tick_1hz);
    endtask

    task automatic set_sw(int b, logic v);
        if (b == 0) i_sw0 = v;
        else if (b == 1) i_sw1 = v;
        else i_sw2 = v;
    endtask

    task automatic press(int b);
        set_sw(b, 1'b0);
        repeat (14) step();
        set_sw(b, 1'b1);
        repeat (14) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, c0, c1, c2, run, seen, hold[3];
        logic [5:0] prev;
        logic found;
        repeat (2) step();
        chk("rst_mode", int'(o_mode), 0);
        chk("rst_pos", int'(o_position), 0);
        chk("rst_mask", int'(o_blink_mask), 0);
        chk("rst_incs", int'({o_sec_inc, o_min_inc, o_hour_inc, o_tick_1hz}), 0);
        rst = 0;
        n = 0;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (o_sec_inc) begin n++; chk("tick_cycle", j + 1, 10 * n); end
        end
        chk("tick_count", n, 3);

        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin step(); found = o_tick_1hz; end
        chk("tick_found", int'(found), 1);
        i_sec_wrap = 1; i_min_wrap = 1;
        #1;
        chk("chain_all", int'({o_sec_inc, o_min_inc, o_hour_inc}), 7);
        i_sec_wrap = 0; i_min_wrap = 0;
        step();
        chk("chain_after", int'({o_sec_inc, o_min_inc, o_hour_inc}), 0);

        press(0);
        chk("setup_mode", int'(o_mode), 1);
        chk("setup_pos", int'(o_position), 0);
        c0 = cnt_tick;
        repeat (20) step();
        chk("setup_tick_silent", cnt_tick - c0, 0);
        press(1);
        press(1);
        chk("pos_hour", int'(o_position), 2);
        c0 = cnt_sec; c1 = cnt_min; c2 = cnt_hour;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 28; s++) begin
                i_sw2 = s >= 14;
                i_sec_wrap = 1'($urandom_range(0, 1));
                step();
            end
        i_sec_wrap = 0;
        chk("hour_pulses", cnt_hour - c2, 3);
        chk("sec_pulses_setup", cnt_sec - c0, 0);
        chk("min_pulses_setup", cnt_min - c1, 0);

        press(1);
        press(1);
        chk("pos_min", int'(o_position), 1);
        prev = o_blink_mask; run = 0; seen = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            chk("blink_val", int'(o_blink_mask == 6'b0 || o_blink_mask == 6'b001100), 1);
            run++;
            if (o_blink_mask != prev) begin
                if (seen != 0) chk("blink_run", run, 5);
                seen = 1; run = 0; prev = o_blink_mask;
            end
        end

        i_sw0 = 0;
        found = 0;
        for (int j = 0; j < 40 && !found; j++) begin step(); found = !o_mode; end
        chk("exit_found", int'(found), 1);
        chk("exit_mask", int'(o_blink_mask), 0);
        n = 0; found = 0;
        for (int j = 0; j < 20 && !found; j++) begin step(); n++; found = o_sec_inc; end
        chk("first_sec_cycle", n + 1, 10);
        i_sw0 = 1;
        repeat (14) step();

        press(0);
        c0 = cnt_sec;
        for (int j = 0; j < 40; j++) begin i_sw2 = (mk + 1) % 4 >= 2; step(); end
        i_sw2 = 1;
        repeat (14) step();
        chk("bounce_no_inc", cnt_sec - c0, 0);
        c0 = cnt_sec;
        i_sw2 = 0;
        repeat (40) step();
        i_sw2 = 1;
        repeat (14) step();
        chk("held_one_inc", cnt_sec - c0, 1);
        press(1);
        press(1);
        c2 = cnt_hour;
        i_sw0 = 0; i_sw2 = 0;
        repeat (14) step();
        i_sw0 = 1; i_sw2 = 1;
        repeat (14) step();
        chk("simul_mode", int'(o_mode), 0);
        chk("simul_no_inc", cnt_hour - c2, 0);

        press(0);
        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin step(); found = o_blink_mask != 0; end
        chk("phase1_found", int'(found), 1);
        i_sw1 = 0;
        rst = 1;
        #1;
        chk("arst_mode", int'(o_mode), 0);
        chk("arst_pos", int'(o_position), 0);
        chk("arst_mask", int'(o_blink_mask), 0);
        repeat (3) step();
        rst = 0;
        repeat (10) step();
        press(0);
        repeat (20) step();
        chk("held_mode", int'(o_mode), 1);
        chk("held_pos", int'(o_position), 0);
        i_sw1 = 1;
        repeat (14) step();
        press(1);
        chk("rearm_pos", int'(o_position), 1);

        hold = '{0, 0, 0};
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    set_sw(b, 1'($urandom_range(0, 1)));
                    hold[b] = $urandom_range(1, 20);
                end
                hold[b]--;
            end
            i_sec_wrap = $urandom_range(0, 7) == 0;
            i_min_wrap = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 399) == 0;
            step();
        end
        rst = 0; i_sw0 = 1; i_sw1 = 1; i_sw2 = 1; i_sec_wrap = 0; i_min_wrap = 0;
        repeat (20) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hms_clock_ctrl.md
# hms_clock_ctrl

Synchronous mode/setup controller for the HMS digital clock. It sits between the push-button inputs and the seconds, minutes and hours counters. It replaces switch-derived and gated clocks with single-cycle increment enables, all on one system clock. It also supplies a per-digit blink mask to the display multiplexer while the clock is being set.

## Interface

- CLK_HZ, 50_000_000, system clock cycles per 1 Hz time tick
- DEB_DIV, 500_000, cycles between debounce samples (100 Hz at 50 MHz)
- BLINK_DIV, 25_000_000, cycles per blink half-period
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_sw0  input  1  mode button, active-low (0 = pressed), asynchronous to clk
- i_sw1  input  1  position button, active-low, asynchronous
- i_sw2  input  1  increment button, active-low, asynchronous
- i_sec_wrap  input  1  one-cycle pulse from the seconds counter when it wraps 59->0
- i_min_wrap  input  1  one-cycle pulse from the minutes counter when it wraps 59->0
- o_mode  output  1  0 = CLOCK, 1 = SETUP
- o_position  output  2  0 = SEC, 1 = MIN, 2 = HOUR; 3 never driven
- o_sec_inc  output  1  one-cycle increment enable, seconds counter
- o_min_inc  output  1  one-cycle increment enable, minutes counter
- o_hour_inc  output  1  one-cycle increment enable, hours counter
- o_blink_mask  output  6  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour
- o_tick_1hz  output  1  one-cycle pulse every CLK_HZ cycles (raw time base)

## Operation

- Reset values: o_mode=0, o_position=0, o_sec_inc=o_min_inc=o_hour_inc=0, o_blink_mask=0, o_tick_1hz=0.
- Reset also clears all prescalers, the blink phase (0 = visible), and the debounce state (all buttons released).

**Input conditioning, per button**
- Two-flop synchroniser into clk.
- Sample the synchronised value when the DEB_DIV prescaler wraps.
- The debounced level changes only when two consecutive samples agree.
- A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate nothing.

**1 Hz time base**
- Counter runs 0..CLK_HZ-1; o_tick_1hz pulses on the cycle the counter equals CLK_HZ-1.
- The counter is held at 0 while in SETUP.

**Mode FSM**
- CLOCK, sw0 press -> SETUP. On entry, o_position <= SEC and blink phase <= 0.
- SETUP, sw0 press -> CLOCK. On exit, the 1 Hz counter restarts from 0.
- No other transitions.

**CLOCK mode**
- o_sec_inc = o_tick_1hz.
- o_min_inc = i_sec_wrap.
- o_hour_inc = i_min_wrap.
- Combinational pass-through of the wrap inputs, zero added latency. All three enables may assert in the same cycle.
- sw1 and sw2 presses are ignored.
- o_blink_mask = 0.

**SETUP mode**
- sw1 press advances position SEC->MIN->HOUR->SEC.
- sw2 press produces exactly one one-cycle increment pulse on the enable for the current position.
- Wrap inputs are ignored; there is no carry into the next unit.
- o_tick_1hz stays low.
- Blink counter runs 0..BLINK_DIV-1 and toggles the phase on wrap. While phase=1, the two mask bits of the current position are 1 and all others are 0.

**Priority, press events in the same cycle**
- sw0 beats sw1 and sw2; the lower-priority events are dropped.
- sw1 beats sw2; the increment is dropped.

## Timing

- Button to event latency: 2 sync cycles plus two debounce sample points, i.e. at most 2 + 2*DEB_DIV cycles after a clean edge.
- Event to output latency:
  - Increment enable, mode change and position change are all registered and appear 1 cycle after the press-event pulse.
  - A press-driven increment enable is exactly 1 cycle wide.
- First o_tick_1hz occurs CLK_HZ cycles after rst deasserts.
- After a SETUP->CLOCK transition, the next o_sec_inc occurs exactly CLK_HZ cycles after the o_mode falling edge.
- Mask follows the o_position update on the same cycle. A position change mid-blink keeps the current phase.
- rst asserted mid-operation:
  - All outputs reach reset values immediately (asynchronously).
  - A button held through reset produces no event after release of rst until it has been released and pressed again.
- Bouncing input (toggling faster than DEB_DIV) produces no event.
- Holding a button produces exactly one event.

## Test plan

All scenarios use CLK_HZ=10, DEB_DIV=4, BLINK_DIV=5.

- **Reset and time base.** Reset, release, idle -> o_sec_inc pulses at cycles 10, 20, 30 after release; all other outputs 0.
- **Wrap chaining.** CLOCK mode; inject i_sec_wrap and i_min_wrap on the same cycle as o_tick_1hz -> o_sec_inc, o_min_inc and o_hour_inc all high that cycle only.
- **Setup increments.**
  - sw0 press -> o_mode=1, o_position=0, o_tick_1hz silent.
  - sw1 pressed twice -> o_position=2.
  - sw2 pressed 3 times -> exactly 3 single-cycle o_hour_inc pulses and zero o_sec_inc/o_min_inc.
  - i_sec_wrap pulses injected meanwhile -> no o_min_inc.
- **Blink.** In SETUP, position MIN -> o_blink_mask alternates 6'b000000 / 6'b001100 every 5 cycles; after a sw0 press, mask = 0 and the first o_sec_inc comes 10 cycles after o_mode falls.
- **Debounce.**
  - i_sw2 toggled every 2 cycles for 40 cycles -> no o_sec_inc.
  - Held low for 40 cycles -> exactly one pulse.
  - sw0 and sw2 simultaneous -> mode toggles, no increment.
- **Reset mid-operation.** Assert rst while in SETUP with phase=1 and i_sw1 held low -> o_mode=0, o_position=0, mask=0 immediately; after rst release with i_sw1 still held, o_position stays 0.
